// File: rtl/adc_sample_logger.sv
// adc_sample_logger
//   Sits behind the 12-bit slow ADC reader.
//   - Watches the reader's step counter (cnt20) for the finished-conversion value.
//   - Captures the sample into a circular FIFO.
//   - Re-arms the reader by pulsing its active-low reset for REARM_CYC cycles.
//   - Keeps running statistics: max, threshold flag, conversion count.
//
// Ports
//   clk, rst       system clock; asynchronous active-low reset
//   enable         1 runs acquisition, 0 holds the reader in reset
//   clr            synchronous clear of FIFO, overflow, max_sample, sample_cnt
//   cnt20, sample  reader step counter and reader data
//   adc_rst_n      registered active-low reset driven back to the reader
//   rd_en          pop request
//   rd_data        popped sample
//   rd_valid       one-cycle strobe qualifying rd_data
//   count          FIFO occupancy
//   empty, full    FIFO occupancy flags
//   overflow       sticky: a capture was dropped because the FIFO was full
//   over_thresh    last captured sample >= THRESH
//   max_sample     largest sample captured
//   sample_cnt     conversions captured, including dropped ones
module adc_sample_logger #(
    parameter int          DEPTH     = 16,
    parameter int          AW        = 4,
    parameter logic [11:0] THRESH    = 12'd2048,
    parameter int          REARM_CYC = 4,
    parameter logic [6:0]  DONE_STEP = 7'd22
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          enable,
    input  logic          clr,
    input  logic [6:0]    cnt20,
    input  logic [11:0]   sample,
    output logic          adc_rst_n,
    input  logic          rd_en,
    output logic [11:0]   rd_data,
    output logic          rd_valid,
    output logic [AW:0]   count,
    output logic          empty,
    output logic          full,
    output logic          overflow,
    output logic          over_thresh,
    output logic [11:0]   max_sample,
    output logic [15:0]   sample_cnt
);

    localparam logic [1:0] IDLE      = 2'd0;
    localparam logic [1:0] WAIT_DONE = 2'd1;
    localparam logic [1:0] CAPTURE   = 2'd2;
    localparam logic [1:0] REARM     = 2'd3;

    localparam logic [7:0]  REARM_LOAD = 8'(REARM_CYC - 1);
    localparam logic [AW:0] DEPTH_CNT  = (AW+1)'(DEPTH);

    function automatic logic [11:0] max_u12(input logic [11:0] a, input logic [11:0] b);
        return (a > b) ? a : b;
    endfunction

    function automatic logic at_or_above(input logic [11:0] s, input logic [11:0] lvl);
        return (s >= lvl);
    endfunction

    logic [1:0]    state;
    logic [7:0]    rearm_cnt;
    logic [AW-1:0] wptr;
    logic [AW-1:0] rptr;
    logic [11:0]   mem [DEPTH];

    logic cap;
    logic pop;
    logic push;

    // A capture only counts while still enabled and not being cleared.
    assign cap   = (state == CAPTURE) && enable && !clr;
    assign pop   = rd_en && !empty;
    // When full, a same-cycle pop frees the slot being written.
    assign push  = cap && (!full || pop);
    assign empty = (count == '0);
    assign full  = (count == DEPTH_CNT);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            adc_rst_n <= 1'b0;
            rearm_cnt <= '0;
        end else if (!enable) begin
            state     <= IDLE;
            adc_rst_n <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    adc_rst_n <= 1'b1;
                    state     <= WAIT_DONE;
                end
                WAIT_DONE: begin
                    if (cnt20 == DONE_STEP) state <= CAPTURE;
                end
                CAPTURE: begin
                    adc_rst_n <= 1'b0;
                    rearm_cnt <= REARM_LOAD;
                    state     <= REARM;
                end
                default: begin
                    if (rearm_cnt == 8'd0) begin
                        adc_rst_n <= 1'b1;
                        state     <= WAIT_DONE;
                    end else begin
                        rearm_cnt <= rearm_cnt - 8'd1;
                    end
                end
            endcase
        end
    end

    // Sample storage carries no reset; occupancy is tracked by the pointers.
    always_ff @(posedge clk) begin
        if (push) mem[wptr] <= sample;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else if (clr) begin
            wptr     <= '0;
            rptr     <= '0;
            count    <= '0;
            overflow <= 1'b0;
        end else begin
            if (push) wptr <= wptr + AW'(1);
            if (pop)  rptr <= rptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + (AW+1)'(1);
                2'b01:   count <= count - (AW+1)'(1);
                default: count <= count;
            endcase
            if (cap && full && !pop) overflow <= 1'b1;
        end
    end

    // Pops still complete during clr.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rd_data  <= '0;
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= pop;
            if (pop) rd_data <= mem[rptr];
        end
    end

    // Dropped captures still feed the statistics.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            max_sample  <= '0;
            sample_cnt  <= '0;
            over_thresh <= 1'b0;
        end else if (clr) begin
            max_sample  <= '0;
            sample_cnt  <= '0;
        end else if (cap) begin
            max_sample  <= max_u12(sample, max_sample);
            sample_cnt  <= sample_cnt + 16'd1;
            over_thresh <= at_or_above(sample, THRESH);
        end
    end

endmodule

// File: tb/tb_adc_sample_logger.sv
// tb_adc_sample_logger
//   Directed + randomized bench for adc_sample_logger with a queue-based
//   reference model of the FIFO and statistics.
module tb_adc_sample_logger;

    localparam int DEPTH = 16;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        enable = 1'b0;
    logic        clr = 1'b0;
    logic [6:0]  cnt20 = '0;
    logic [11:0] sample = '0;
    logic        adc_rst_n;
    logic        rd_en = 1'b0;
    logic [11:0] rd_data;
    logic        rd_valid;
    logic [4:0]  count;
    logic        empty;
    logic        full;
    logic        overflow;
    logic        over_thresh;
    logic [11:0] max_sample;
    logic [15:0] sample_cnt;

    adc_sample_logger dut (
        .clk(clk), .rst(rst), .enable(enable), .clr(clr),
        .cnt20(cnt20), .sample(sample), .adc_rst_n(adc_rst_n),
        .rd_en(rd_en), .rd_data(rd_data), .rd_valid(rd_valid),
        .count(count), .empty(empty), .full(full), .overflow(overflow),
        .over_thresh(over_thresh), .max_sample(max_sample), .sample_cnt(sample_cnt)
    );

    always #10 clk = ~clk;

    // reference model
    logic [11:0] q[$];
    bit          m_ovf;
    logic [11:0] m_max;
    logic [15:0] m_cnt;
    bit          m_ot;
    logic [11:0] last_rd;

    int ncmp = 0;
    int nerr = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ncmp++;
        assert (obs === exp) else begin
            nerr++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        chk("count",       32'(count),       32'(q.size()));
        chk("empty",       32'(empty),       32'(q.size() == 0));
        chk("full",        32'(full),        32'(q.size() == DEPTH));
        chk("overflow",    32'(overflow),    32'(m_ovf));
        chk("over_thresh", 32'(over_thresh), 32'(m_ot));
        chk("max_sample",  32'(max_sample),  32'(m_max));
        chk("sample_cnt",  32'(sample_cnt),  32'(m_cnt));
    endtask

    // Reader model: runs one conversion ending at step 22 with value v.
    // mode 0 plain, 1 pop in the capture cycle, 2 disable in the capture cycle.
    task automatic convert(input logic [11:0] v, input int mode);
        int n;
        logic [11:0] e;
        n = 0;
        while (adc_rst_n !== 1'b1 && n < 100) begin
            @(negedge clk);
            n++;
        end
        if (n >= 100) chk("arm_timeout", 32'(adc_rst_n), 32'd1);
        sample = v;
        for (int k = 1; k <= 22; k++) begin
            cnt20 = 7'(k);
            @(negedge clk);
        end
        cnt20 = '0;
        if (mode == 1) rd_en = 1'b1;
        if (mode == 2) enable = 1'b0;
        @(negedge clk);
        rd_en = 1'b0;
        if (mode == 2) begin
            chk("dis_cap_rstn", 32'(adc_rst_n), 32'd0);
            check_all();
            enable = 1'b1;
        end else begin
            chk("cap_rstn", 32'(adc_rst_n), 32'd0);
            if (mode == 1) begin
                if (q.size() > 0) begin
                    e = q.pop_front();
                    chk("cap_pop_valid", 32'(rd_valid), 32'd1);
                    chk("cap_pop_data",  32'(rd_data),  32'(e));
                    last_rd = e;
                end else begin
                    chk("cap_pop_valid", 32'(rd_valid), 32'd0);
                end
            end
            if (q.size() < DEPTH) q.push_back(v);
            else m_ovf = 1'b1;
            m_cnt++;
            if (v > m_max) m_max = v;
            m_ot = (v >= 12'd2048);
            check_all();
        end
    endtask

    task automatic do_pop();
        logic [11:0] e;
        rd_en = 1'b1;
        @(negedge clk);
        rd_en = 1'b0;
        if (q.size() > 0) begin
            e = q.pop_front();
            chk("pop_valid", 32'(rd_valid), 32'd1);
            chk("pop_data",  32'(rd_data),  32'(e));
            last_rd = e;
        end else begin
            chk("pop_empty_valid", 32'(rd_valid), 32'd0);
            chk("pop_empty_data",  32'(rd_data),  32'(last_rd));
        end
        chk("pop_count", 32'(count), 32'(q.size()));
    endtask

    task automatic do_clr();
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        q.delete();
        m_ovf = 1'b0;
        m_max = '0;
        m_cnt = '0;
        check_all();
    endtask

    initial begin
        #5000000;
        $display("FAIL watchdog: observed timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        m_ovf = 0; m_max = '0; m_cnt = '0; m_ot = 0; last_rd = '0;

        // reset values
        repeat (2) @(negedge clk);
        chk("rst_adc_rst_n", 32'(adc_rst_n), 32'd0);
        chk("rst_rd_data",   32'(rd_data),   32'd0);
        chk("rst_rd_valid",  32'(rd_valid),  32'd0);
        check_all();

        // release and enable: reader comes out of reset one edge later
        rst = 1'b1;
        enable = 1'b1;
        @(negedge clk);
        chk("arm_rstn", 32'(adc_rst_n), 32'd1);

        // single capture + re-arm pulse width + pop
        convert(12'hABC, 0);
        n = 0;
        while (adc_rst_n == 1'b0 && n < 20) begin
            n++;
            @(negedge clk);
        end
        chk("rearm_low_cycles", 32'(n), 32'd4);
        do_pop();
        @(negedge clk);
        chk("rd_valid_drop", 32'(rd_valid), 32'd0);
        do_pop();   // empty: ignored, data held

        // fill to overflow, then drain in order
        do_clr();
        for (int i = 1; i <= 17; i++) convert(12'(i), 0);
        for (int i = 0; i < 17; i++) do_pop();

        // full FIFO with push+pop in the same cycle across pointer wrap
        do_clr();
        for (int i = 0; i < 16; i++) convert(12'($urandom), 0);
        for (int i = 0; i < 5; i++) convert(12'($urandom), 1);
        for (int i = 0; i < 17; i++) do_pop();

        // threshold boundary, then clr while the FSM keeps running
        convert(12'd2047, 0);
        convert(12'd2048, 0);
        do_clr();
        convert(12'h123, 0);

        // disable during capture: dropped, then resumes
        convert(12'hFFF, 2);
        convert(12'h055, 0);

        // disable just before the re-arm would release
        repeat (3) @(negedge clk);
        enable = 1'b0;
        @(negedge clk);
        chk("dis_rearm_rstn", 32'(adc_rst_n), 32'd0);
        enable = 1'b1;
        @(negedge clk);
        chk("reen_rstn", 32'(adc_rst_n), 32'd1);
        convert(12'h321, 0);

        // randomized captures with interleaved pops
        for (int i = 0; i < 40; i++) begin
            convert(12'($urandom), ($urandom_range(0, 2) == 0) ? 1 : 0);
            if ($urandom_range(0, 1) == 1) do_pop();
        end

        // asynchronous reset mid re-arm
        #3;
        rst = 1'b0;
        #1;
        chk("arst_rstn",    32'(adc_rst_n),  32'd0);
        chk("arst_count",   32'(count),      32'd0);
        chk("arst_empty",   32'(empty),      32'd1);
        chk("arst_max",     32'(max_sample), 32'd0);
        chk("arst_cnt",     32'(sample_cnt), 32'd0);
        chk("arst_ovf",     32'(overflow),   32'd0);
        chk("arst_rdvalid", 32'(rd_valid),   32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nerr);
        $finish;
    end

endmodule

// File: doc/adc_sample_logger.md
# adc_sample_logger

Downstream consumer of the 12-bit slow ADC reader in the Data_Collector path. It watches the reader's step counter for conversion completion and captures the finished 12-bit sample into a DEPTH-entry FIFO. It then re-arms the reader by pulsing the reader's active-low reset, and tracks running statistics: maximum, threshold flag and conversion count. A host-side read port drains the FIFO.

## Interface
- DEPTH, 16, FIFO entries; power of two, 2..256
- AW, 4, pointer width; log2(DEPTH)
- THRESH, 12'd2048, over-threshold compare level
- REARM_CYC, 4, clk cycles adc_rst_n is held low per re-arm; 1..255
- DONE_STEP, 7'd22, reader step-counter value that marks a finished conversion
- clk  input  1  system clock, 50 MHz
- rst  input  1  asynchronous, active-low reset
- enable  input  1  1 = run acquisition; 0 = hold reader in reset
- clr  input  1  synchronous clear of FIFO, overflow, max_sample, sample_cnt
- cnt20  input  7  reader step counter
- sample  input  12  reader data; stable once cnt20 == DONE_STEP
- adc_rst_n  output  1  registered, active-low reset to reader
- rd_en  input  1  pop request
- rd_data  output  12  popped sample, registered
- rd_valid  output  1  one-cycle strobe; rd_data valid
- count  output  AW+1  entries held, 0..DEPTH
- empty  output  1  count == 0
- full  output  1  count == DEPTH
- overflow  output  1  sticky; a capture was dropped because the FIFO was full
- over_thresh  output  1  last captured sample >= THRESH
- max_sample  output  12  largest sample captured since reset or clr
- sample_cnt  output  16  conversions captured, including dropped ones; wraps at 65535 -> 0

## Operation
- Reset values: FSM IDLE; adc_rst_n 0; rd_data 0; rd_valid 0; count 0; empty 1; full 0; overflow 0; over_thresh 0; max_sample 0; sample_cnt 0; pointers 0.
- FSM states: IDLE, WAIT_DONE, CAPTURE, REARM.
  - IDLE: adc_rst_n = 0. If enable = 1: set adc_rst_n <= 1 and go to WAIT_DONE.
  - WAIT_DONE: if cnt20 == DONE_STEP, go to CAPTURE.
  - CAPTURE: write sample if not full, otherwise set overflow. Update max_sample, over_thresh and sample_cnt. Set adc_rst_n <= 0, load the re-arm counter with REARM_CYC-1, go to REARM.
  - REARM: decrement the counter. At 0, set adc_rst_n <= 1 and go to WAIT_DONE.
  - Any state with enable = 0: go to IDLE next edge and set adc_rst_n <= 0. A capture pending in that same cycle is discarded.
- FIFO: circular, write and read pointers AW bits wide, wrapping DEPTH-1 -> 0.
  - Write in CAPTURE when !full, or when full and a pop occurs the same cycle.
  - Pop when rd_en && !empty. On pop, rd_data <= mem[rptr] and rd_valid <= 1 on the next edge.
  - rd_en while empty is ignored: rd_valid 0, rd_data held.
  - Simultaneous push and pop: count unchanged, both pointers advance, no overflow.
- max_sample uses an unsigned 12-bit compare: update when sample > max_sample. Dropped captures still update max_sample, over_thresh and sample_cnt.
- clr: pointers, count, overflow, max_sample and sample_cnt return to reset values on the next edge. FSM and adc_rst_n are unaffected.
  - A capture in the same cycle as clr is discarded.
  - A pop in the same cycle as clr returns valid data.
- rst asserted mid-operation clears everything immediately and drives adc_rst_n low, so the reader is also reset.

## Timing
- Edge E0 samples cnt20 == DONE_STEP in WAIT_DONE; state becomes CAPTURE.
- Edge E1 writes the FIFO; count, flags and statistics are visible after E1. adc_rst_n falls at E1.
- adc_rst_n stays low for exactly REARM_CYC cycles and rises at edge E1+REARM_CYC.
- Capture-to-capture period = reader conversion time (about 22×28 clk) + REARM_CYC + 2.
- Pop latency is 1 cycle: rd_en at edge N gives rd_valid and rd_data after edge N; rd_valid deasserts the following cycle unless popped again.
- empty, full and count are registered and reflect all operations of the previous edge.

## Test plan
- Reset: rst low, all outputs at reset values. enable=1, rst high: adc_rst_n rises 1 cycle later and FSM is in WAIT_DONE.
- Single capture: model drives cnt20 0 -> 22 with sample=12'hABC. Required: count=1 after E1; adc_rst_n low exactly 4 cycles; max_sample=ABC; over_thresh=1; sample_cnt=1. rd_en then gives rd_data=ABC with rd_valid 1 cycle later and empty=1.
- Fill/overflow: 17 conversions, samples 1..17, no reads. Required: full=1 after the 16th; overflow=1 after the 17th; FIFO still holds 1..16; sample_cnt=17; max_sample=17.
- Simultaneous push/pop when full: count stays 16, overflow stays 0, output order preserved across pointer wrap.
- Threshold and clr: sample 2047 gives over_thresh=0; sample 2048 gives over_thresh=1. clr then gives count=0, empty=1, max_sample=0, overflow=0, with the FSM still running.
- Disable mid-REARM and in CAPTURE: enable=0 gives IDLE next edge and adc_rst_n=0; the capture is discarded and count is unchanged. Re-enable resumes normal captures.
